// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: major opcodes, immediate formats, zero constant.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate generator; the opcode field is not needed here, only ins[31:7].
module id_imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     ins_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = ZeroWord;
    case (fmt_i)
      IMM_I: imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
      IMM_S: imm32 = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
      IMM_B: imm32 = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
      IMM_U: imm32 = {ins_i[31:12], 12'h000};
      IMM_J: imm32 = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
      default: imm32 = ZeroWord;
    endcase
  end

  // Signed cast extends ins[31] to the full datapath width.
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_v2.sv
// RV32I decode stage with operand bypass, load-use bubble insertion and an ID/EX register.
module id_stage_v2
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             if_valid_in,
  output logic             if_ready_out,
  input  logic [XLEN-1:0]  if_pc_in,
  input  logic [31:0]      if_ins_in,
  output logic [4:0]       rs1_addr_out,
  input  logic [XLEN-1:0]  rs1_data_in,
  output logic [4:0]       rs2_addr_out,
  input  logic [XLEN-1:0]  rs2_data_in,
  input  logic             ex_wr_en_in,
  input  logic [4:0]       ex_wr_addr_in,
  input  logic [XLEN-1:0]  ex_wr_data_in,
  input  logic             ex_is_load_in,
  input  logic             mem_wr_en_in,
  input  logic [4:0]       mem_wr_addr_in,
  input  logic [XLEN-1:0]  mem_wr_data_in,
  input  logic             flush_in,
  output logic             ex_valid_out,
  input  logic             ex_ready_in,
  output logic [XLEN-1:0]  pc_out,
  output logic [4:0]       r1_addr_out,
  output logic [XLEN-1:0]  r1_data_out,
  output logic [4:0]       r2_addr_out,
  output logic [XLEN-1:0]  r2_data_out,
  output logic [4:0]       rd_addr_out,
  output logic [XLEN-1:0]  imm_out,
  output logic [6:0]       opcode_out,
  output logic [2:0]       funct3_out,
  output logic             funct7b5_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;
  localparam logic FWD      = (FWD_EN != 0);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       known, illegal, use_rs1, use_rs2, use_rd, f7b5;
  imm_fmt_e   fmt;
  logic [XLEN-1:0] imm, op1, op2;
  logic [4:0] rs1_a, rs2_a, rd_a;
  logic       ex_hit, mem_hit, hazard, free, accept;

  logic            state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, r1_data_q, r1_data_d, r2_data_q, r2_data_d, imm_q, imm_d;
  logic [4:0]      r1_addr_q, r1_addr_d, r2_addr_q, r2_addr_d, rd_addr_q, rd_addr_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            f7b5_q, f7b5_d, illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    opc     = if_ins_in[6:0];
    f3      = if_ins_in[14:12];
    known   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    fmt     = IMM_NONE;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin use_rd = 1'b1; fmt = IMM_U; end
      OPC_JAL:    begin use_rd = 1'b1; fmt = IMM_J; end
      OPC_JALR:   begin use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; end
      OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_B; end
      OPC_LOAD:   begin use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; end
      OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; fmt = IMM_S; end
      OPC_OP_IMM: begin use_rd = 1'b1; use_rs1 = 1'b1; fmt = IMM_I; end
      OPC_OP:     begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      default:    known = 1'b0;
    endcase
    illegal = !known || (opc == OPC_JALR && f3 != 3'b000);
    f7b5    = (opc == OPC_OP || (opc == OPC_OP_IMM && f3 == 3'b101)) ? if_ins_in[30] : 1'b0;
    // Addresses of unused or illegal fields read as x0 so they never match a writer.
    rs1_a   = (use_rs1 && !illegal && rst_in) ? if_ins_in[19:15] : 5'd0;
    rs2_a   = (use_rs2 && !illegal && rst_in) ? if_ins_in[24:20] : 5'd0;
    rd_a    = (use_rd && !illegal) ? if_ins_in[11:7] : 5'd0;
  end

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ins_i (if_ins_in[31:7]),
    .fmt_i (fmt),
    .imm_o (imm)
  );

  always_comb begin
    if (rs1_a == 5'd0)
      op1 = '0;
    else if (FWD && ex_wr_en_in && !ex_is_load_in && ex_wr_addr_in == rs1_a)
      op1 = ex_wr_data_in;
    else if (FWD && mem_wr_en_in && mem_wr_addr_in == rs1_a)
      op1 = mem_wr_data_in;
    else
      op1 = rs1_data_in;

    if (rs2_a == 5'd0)
      op2 = '0;
    else if (FWD && ex_wr_en_in && !ex_is_load_in && ex_wr_addr_in == rs2_a)
      op2 = ex_wr_data_in;
    else if (FWD && mem_wr_en_in && mem_wr_addr_in == rs2_a)
      op2 = mem_wr_data_in;
    else
      op2 = rs2_data_in;
  end

  assign ex_hit  = ex_wr_en_in && ex_wr_addr_in != 5'd0 &&
                   (ex_wr_addr_in == rs1_a || ex_wr_addr_in == rs2_a);
  assign mem_hit = mem_wr_en_in && mem_wr_addr_in != 5'd0 &&
                   (mem_wr_addr_in == rs1_a || mem_wr_addr_in == rs2_a);
  assign hazard  = if_valid_in && ((ex_hit && (ex_is_load_in || !FWD)) || (!FWD && mem_hit));
  assign free    = (state_q == ST_EMPTY) || ex_ready_in;
  assign if_ready_out = rdy_in && rst_in && (flush_in || (!hazard && free));
  assign accept  = if_valid_in && if_ready_out;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    r1_addr_d = r1_addr_q;
    r1_data_d = r1_data_q;
    r2_addr_d = r2_addr_q;
    r2_data_d = r2_data_q;
    rd_addr_d = rd_addr_q;
    imm_d     = imm_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    f7b5_d    = f7b5_q;
    illegal_d = illegal_q;
    stall_d   = stall_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = ST_EMPTY;
      end else if (accept) begin
        state_d   = ST_FULL;
        pc_d      = if_pc_in;
        r1_addr_d = rs1_a;
        r1_data_d = op1;
        r2_addr_d = rs2_a;
        r2_data_d = op2;
        rd_addr_d = rd_a;
        imm_d     = imm;
        opcode_d  = opc;
        funct3_d  = f3;
        f7b5_d    = f7b5;
        illegal_d = illegal;
      end else if (state_q == ST_FULL && ex_ready_in) begin
        state_d = ST_EMPTY;
      end
      if (!flush_in && hazard && free && stall_q != '1)
        stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_EMPTY;
      pc_q      <= '0;
      r1_addr_q <= '0;
      r1_data_q <= '0;
      r2_addr_q <= '0;
      r2_data_q <= '0;
      rd_addr_q <= '0;
      imm_q     <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      f7b5_q    <= 1'b0;
      illegal_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      r1_addr_q <= r1_addr_d;
      r1_data_q <= r1_data_d;
      r2_addr_q <= r2_addr_d;
      r2_data_q <= r2_data_d;
      rd_addr_q <= rd_addr_d;
      imm_q     <= imm_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      f7b5_q    <= f7b5_d;
      illegal_q <= illegal_d;
      stall_q   <= stall_d;
    end
  end

  assign rs1_addr_out  = rs1_a;
  assign rs2_addr_out  = rs2_a;
  assign ex_valid_out  = (state_q == ST_FULL);
  assign pc_out        = pc_q;
  assign r1_addr_out   = r1_addr_q;
  assign r1_data_out   = r1_data_q;
  assign r2_addr_out   = r2_addr_q;
  assign r2_data_out   = r2_data_q;
  assign rd_addr_out   = rd_addr_q;
  assign imm_out       = imm_q;
  assign opcode_out    = opcode_q;
  assign funct3_out    = funct3_q;
  assign funct7b5_out  = f7b5_q;
  assign illegal_out   = illegal_q;
  assign stall_cnt_out = stall_q;

endmodule

// File: doc/id_stage_v2.md
# id_stage_v2

Registered RV32I decode stage with a valid/ready handshake on both sides and an ID/EX pipeline register. It decodes all base-ISA formats with correctly sign-extended immediates, forwards operands from EX and MEM, and detects load-use hazards, inserting bubbles for them. It also flags illegal encodings and counts stall cycles. It sits between IF and EX and replaces the combinational decoder.

## Interface
- `XLEN`, 32: data/PC width; immediates sign-extend to XLEN.
- `FWD_EN`, 1: 1 enables EX/MEM bypass; 0 takes register-file data only and treats any EX/MEM write match as a hazard.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global enable; 0 freezes all state.
- `if_valid_in` in 1 / `if_ready_out` out 1: upstream handshake.
- `if_pc_in` in XLEN / `if_ins_in` in 32: fetched PC and instruction.
- `rs1_addr_out` out 5 / `rs1_data_in` in XLEN: register-file port 1, combinational, same cycle.
- `rs2_addr_out` out 5 / `rs2_data_in` in XLEN: register-file port 2.
- `ex_wr_en_in` in 1, `ex_wr_addr_in` in 5, `ex_wr_data_in` in XLEN, `ex_is_load_in` in 1: instruction currently in EX.
- `mem_wr_en_in` in 1, `mem_wr_addr_in` in 5, `mem_wr_data_in` in XLEN: instruction currently in MEM.
- `flush_in` in 1: kill the wrong-path instruction.
- `ex_valid_out` out 1 / `ex_ready_in` in 1: downstream handshake.
- `pc_out` out XLEN, `r1_addr_out` out 5, `r1_data_out` out XLEN, `r2_addr_out` out 5, `r2_data_out` out XLEN, `rd_addr_out` out 5, `imm_out` out XLEN: decoded operands.
- `opcode_out` out 7, `funct3_out` out 3, `funct7b5_out` out 1: instruction class and details.
- `illegal_out` out 1: illegal encoding.
- `stall_cnt_out` out CNT_W: load-use bubble count, saturating.

## Operation
- **Register usage by class:**
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
  - rd is written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP; for all other classes rd_addr_out = 0.
  - Unused source addresses drive 0.
- **Immediates by format:**
  - I-type: JALR, LOAD, OP-IMM.
  - S-type: STORE.
  - B-type: BRANCH; bit 0 = 0.
  - U-type: LUI, AUIPC; low 12 bits = 0.
  - J-type: JAL; bit 0 = 0.
  - OP: imm = 0.
  - Every immediate is sign-extended from ins[31] to XLEN.
- **funct7b5_out** = ins[30] for OP, and for OP-IMM only when funct3 = 101; otherwise 0.
- **Illegal encodings:** unknown opcode, or JALR with funct3 ≠ 0.
  - Result: illegal_out = 1, rd/rs addresses forced to 0, instruction still passed downstream.
- **Operand selection, in priority order:**
  - address 0 → 0;
  - EX match (ex_wr_en_in, address match, not a load) → ex_wr_data_in;
  - MEM match → mem_wr_data_in;
  - otherwise → register file.
- **Operand sampling:** operands are sampled once, at acceptance. A held instruction does not re-sample.
- **hazard** = if_valid_in AND ex_wr_en_in AND ex_wr_addr_in ≠ 0 AND (ex_is_load_in OR FWD_EN = 0) AND the EX address matches a used source.
  - With FWD_EN = 0, a MEM match also raises hazard.
- **if_ready_out** = rdy_in AND (flush_in OR (NOT hazard AND (NOT ex_valid_out OR ex_ready_in))).
- **Output register states:**
  - EMPTY: ex_valid_out = 0.
  - FULL: ex_valid_out = 1.
- **Transitions, evaluated only when rdy_in = 1, in priority order:**
  - flush_in → EMPTY; the incoming instruction is consumed and dropped.
  - Accept (if_valid_in AND if_ready_out) → FULL with new contents.
  - FULL with ex_ready_in = 1 and no accept → EMPTY.
  - FULL with ex_ready_in = 0 → hold; all outputs stable.
- **Bubble:** hazard with the output register free → EMPTY. stall_cnt_out increments by 1 per such cycle and saturates at all-ones.

## Timing
- Latency: 1 cycle from accept to ex_valid_out.
- Throughput: 1 instruction per cycle with no hazard.
- Load-use penalty: exactly 1 bubble, provided EX advances the load to MEM the next cycle.
- **Reset (rst_in = 0):** all registered outputs 0, ex_valid_out = 0, stall_cnt_out = 0.
  - Asynchronous entry; release is sampled on the first following rising clk_in.
  - Combinational outputs during reset: if_ready_out = 0, rs addresses = 0.
- **Reset mid-operation:** an in-flight instruction is discarded. No handshake completes in the reset cycle.
- **rdy_in = 0:** state and counter frozen, if_ready_out = 0, flush_in ignored. The source holds flush_in until rdy_in = 1.
- **Flush coinciding with a hold** (ex_ready_in = 0): flush wins; ex_valid_out = 0 next cycle.

## Structure
- `rv_pkg` holds:
  - opcode constants LUI/AUIPC/JAL/JALR/BRANCH/LOAD/STORE/OP_IMM/OP;
  - the ZeroWord constant;
  - the immediate-format enum (I/S/B/U/J/NONE).
- `id_imm_gen` sub-module: combinational immediate generator (ins, format → XLEN immediate).
- Operand mux and hazard logic stay inline.

## Test plan
- addi x1,x0,5 (0x00500093), EX/MEM idle → next cycle: ex_valid_out = 1, opcode_out = 0x13, rd_addr_out = 1, r1_addr_out = 0, r1_data_out = 0, imm_out = 0x00000005.
- beq x1,x2,-8 (0xFE208CE3) → imm_out = 0xFFFFFFF8, rd_addr_out = 0, r1/r2 addresses 1/2. jal x1,+2048 (0x001000EF) → imm_out = 0x00000800.
- EX holds lw x5 (ex_is_load_in = 1, ex_wr_addr_in = 5), IF presents add x6,x5,x7 (0x00728333):
  - if_ready_out = 0 for 1 cycle, one bubble, stall_cnt_out = 1.
  - Next cycle, MEM writes x5 = 0x1234 → r1_data_out = 0x1234.
- Both EX and MEM write x3 (EX 0xAAAA, MEM 0xBBBB), IF presents an instruction reading rs1 = x3 → r1_data_out = 0xAAAA. Same case with address x0 → r1_data_out = 0.
- ex_ready_in = 0 while FULL for 3 cycles → outputs unchanged. Then flush_in = 1 → ex_valid_out = 0 next cycle; the instruction at IF is dropped.
- Unknown opcode 0x0000007F → illegal_out = 1, rd_addr_out = 0. rst_in pulsed low mid-stream → all outputs 0 immediately, ex_valid_out = 0.
